// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: the one-hot grant is combinational, and the registered broadcast appears one cycle after the grant.
// There is no backpressure: the CDB is always accepted, and each requester holds its result until it is granted.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 6
`endif

module cdb_arbiter #(
    parameter int NUM_SRC  = 4,
    parameter int XLEN     = 32,
    parameter int ROB_ID_W = `ROB_ID_WIDTH,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_SRC-1:0]           req_valid_i,
    input  logic [NUM_SRC*XLEN-1:0]      req_data_i,
    input  logic [NUM_SRC*ROB_ID_W-1:0]  req_rob_id_i,
    output logic [NUM_SRC-1:0]           grant_o,
    output logic                         cdb_valid_o,
    output logic [XLEN-1:0]              cdb_data_o,
    output logic [ROB_ID_W-1:0]          cdb_rob_id_o,
    output logic [SRC_W-1:0]             cdb_src_o
);

    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                cdb_valid_q, cdb_valid_d;
    logic [XLEN-1:0]     cdb_data_q, cdb_data_d;
    logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [SRC_W-1:0]    cdb_src_q, cdb_src_d;

    logic                win_vld;
    logic [SRC_W-1:0]    win_idx;
    logic                blk;
    int                  idx;

    assign blk = rst | flush;

    // Scan from rr_ptr upward, wrapping modulo NUM_SRC; the first requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!win_vld && req_valid_i[SRC_W'(idx)]) begin
                win_vld = 1'b1;
                win_idx = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        grant_o = '0;
        if (win_vld && !blk) grant_o[win_idx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        cdb_valid_d  = 1'b0;
        cdb_data_d   = cdb_data_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_src_d    = cdb_src_q;
        if (flush) begin
            rr_ptr_d     = '0;
            cdb_data_d   = '0;
            cdb_rob_id_d = '0;
            cdb_src_d    = '0;
        end else if (win_vld) begin
            rr_ptr_d     = (win_idx == SRC_W'(NUM_SRC-1)) ? '0 : win_idx + 1'b1;
            cdb_valid_d  = 1'b1;
            cdb_data_d   = req_data_i[win_idx*XLEN +: XLEN];
            cdb_rob_id_d = req_rob_id_i[win_idx*ROB_ID_W +: ROB_ID_W];
            cdb_src_d    = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_data_q   <= '0;
            cdb_rob_id_q <= '0;
            cdb_src_q    <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_data_q   <= cdb_data_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid_o  = cdb_valid_q;
    assign cdb_data_o   = cdb_data_q;
    assign cdb_rob_id_o = cdb_rob_id_q;
    assign cdb_src_o    = cdb_src_q;

endmodule
